// File: rtl/cluster_pkg.sv
// rtl/cluster_pkg.sv - shared widths, slot codes and helpers for the cluster decoder
package cluster_pkg;

  localparam int STRIP_W    = 128;
  localparam int ADDR_W     = 7;
  localparam int SLOT_W     = 8;
  localparam int DOUBLE_BIT = 7;

  localparam logic [SLOT_W-1:0] EMPTY_SLOT = 8'hFF;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } dec_state_e;

  function automatic logic slot_nonempty(input logic [SLOT_W-1:0] slot);
    return slot != EMPTY_SLOT;
  endfunction

endpackage

// File: rtl/cluster_slot_decode.sv
// rtl/cluster_slot_decode.sv - expands one 8-bit cluster slot into a 128-strip mask
module cluster_slot_decode
  import cluster_pkg::*;
(
  input  logic [SLOT_W-1:0]  slot_i,
  output logic [STRIP_W-1:0] mask_o,
  output logic               empty_o,
  output logic               badcode_o
);

  localparam logic [STRIP_W-1:0] ONE_HOT0 = {{(STRIP_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   addr_p1;
  logic              empty;

  assign addr    = slot_i[ADDR_W-1:0];
  assign addr_p1 = {1'b0, addr} + (ADDR_W+1)'(1);
  assign empty   = !slot_nonempty(slot_i);
  assign empty_o = empty;

  always_comb begin
    mask_o    = '0;
    badcode_o = 1'b0;
    if (!empty) begin
      mask_o = ONE_HOT0 << addr;
      if (slot_i[DOUBLE_BIT]) begin
        // A double on the top strip would run off the map; only 8'hFF uses that code today.
        if (addr == {ADDR_W{1'b1}}) begin
          badcode_o = 1'b1;
        end else begin
          mask_o = mask_o | (ONE_HOT0 << addr_p1);
        end
      end
    end
  end

endmodule

// File: rtl/cluster_decode_128bit.sv
// rtl/cluster_decode_128bit.sv - rebuilds one event's 128-strip hit map from cluster words
module cluster_decode_128bit
  import cluster_pkg::*;
#(
  parameter int MAX_CLUS = 64,
  parameter int CNT_W    = 8
) (
  input  logic               BCclk,
  input  logic               rstb,
  input  logic [15:0]        clus_in,
  input  logic               clus_valid,
  input  logic               clus_last,
  output logic               clus_ready,
  output logic [STRIP_W-1:0] hitmap,
  output logic               hitmap_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   clus_count,
  output logic               err_overflow,
  output logic               err_collision,
  output logic               err_badslot
);

  localparam logic [CNT_W:0] MAX_CLUS_W = (CNT_W+1)'(MAX_CLUS);

  dec_state_e state_q, state_d;

  logic [STRIP_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               col_q, col_d;
  logic               bad_q, bad_d;

  logic [STRIP_W-1:0] hitmap_q, hitmap_d;
  logic [CNT_W-1:0]   count_out_q, count_out_d;
  logic               ovf_out_q, ovf_out_d;
  logic               col_out_q, col_out_d;
  logic               bad_out_q, bad_out_d;

  logic [STRIP_W-1:0] mask0, mask1;
  logic               empty0, empty1;
  logic               badcode0, badcode1;

  cluster_slot_decode u_slot0 (
    .slot_i    (clus_in[SLOT_W-1:0]),
    .mask_o    (mask0),
    .empty_o   (empty0),
    .badcode_o (badcode0)
  );

  cluster_slot_decode u_slot1 (
    .slot_i    (clus_in[2*SLOT_W-1:SLOT_W]),
    .mask_o    (mask1),
    .empty_o   (empty1),
    .badcode_o (badcode1)
  );

  logic               xfer;
  logic [1:0]         n_slots;
  logic [CNT_W:0]     cnt_sum;
  logic [CNT_W-1:0]   cnt_sat;
  logic [STRIP_W-1:0] acc_new;
  logic               col_term;
  logic               bad_term;

  assign clus_ready   = (state_q == ST_ACCUM);
  assign hitmap_valid = (state_q == ST_HOLD);
  assign xfer         = clus_valid && clus_ready;

  assign n_slots  = {1'b0, !empty0} + {1'b0, !empty1};
  assign cnt_sum  = {1'b0, cnt_q} + (CNT_W+1)'(n_slots);
  assign cnt_sat  = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  assign acc_new  = acc_q | mask0 | mask1;
  // Overlap within the word counts as a collision just like overlap with earlier words.
  assign col_term = |(mask0 & acc_q) || |(mask1 & acc_q) || |(mask0 & mask1);
  assign bad_term = (empty0 && !empty1) || badcode0 || badcode1;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    col_d       = col_q;
    bad_d       = bad_q;
    hitmap_d    = hitmap_q;
    count_out_d = count_out_q;
    ovf_out_d   = ovf_out_q;
    col_out_d   = col_out_q;
    bad_out_d   = bad_out_q;

    case (state_q)
      ST_ACCUM: begin
        if (xfer) begin
          if (clus_last) begin
            hitmap_d    = acc_new;
            count_out_d = cnt_sat;
            ovf_out_d   = ovf_q || (cnt_sum > MAX_CLUS_W);
            col_out_d   = col_q || col_term;
            bad_out_d   = bad_q || bad_term;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            col_d       = 1'b0;
            bad_d       = 1'b0;
            state_d     = ST_HOLD;
          end else begin
            acc_d = acc_new;
            cnt_d = cnt_sat;
            ovf_d = ovf_q || (cnt_sum > MAX_CLUS_W);
            col_d = col_q || col_term;
            bad_d = bad_q || bad_term;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge BCclk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      col_q       <= 1'b0;
      bad_q       <= 1'b0;
      hitmap_q    <= '0;
      count_out_q <= '0;
      ovf_out_q   <= 1'b0;
      col_out_q   <= 1'b0;
      bad_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      col_q       <= col_d;
      bad_q       <= bad_d;
      hitmap_q    <= hitmap_d;
      count_out_q <= count_out_d;
      ovf_out_q   <= ovf_out_d;
      col_out_q   <= col_out_d;
      bad_out_q   <= bad_out_d;
    end
  end

  assign hitmap        = hitmap_q;
  assign clus_count    = count_out_q;
  assign err_overflow  = ovf_out_q;
  assign err_collision = col_out_q;
  assign err_badslot   = bad_out_q;

endmodule

// File: tb/tb_cluster_decode_128bit.sv
// tb/tb_cluster_decode_128bit.sv - scoreboard bench for the cluster decoder
module tb_cluster_decode_128bit;

  localparam int MAX_CLUS = 64;
  localparam int CNT_W    = 8;

  logic         BCclk = 1'b0;
  logic         rstb;
  logic [15:0]  clus_in;
  logic         clus_valid;
  logic         clus_last;
  logic         clus_ready;
  logic [127:0] hitmap;
  logic         hitmap_valid;
  logic         out_ready;
  logic [7:0]   clus_count;
  logic         err_overflow;
  logic         err_collision;
  logic         err_badslot;

  always #5 BCclk = ~BCclk;

  cluster_decode_128bit #(.MAX_CLUS(MAX_CLUS), .CNT_W(CNT_W)) dut (
    .BCclk         (BCclk),
    .rstb          (rstb),
    .clus_in       (clus_in),
    .clus_valid    (clus_valid),
    .clus_last     (clus_last),
    .clus_ready    (clus_ready),
    .hitmap        (hitmap),
    .hitmap_valid  (hitmap_valid),
    .out_ready     (out_ready),
    .clus_count    (clus_count),
    .err_overflow  (err_overflow),
    .err_collision (err_collision),
    .err_badslot   (err_badslot)
  );

  typedef struct {
    logic [127:0] map;
    int           cnt;
    bit           ovf;
    bit           col;
    bit           bad;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Event model: a plain strip array plus running tallies.
  bit [127:0] m_map;
  int         m_cnt;
  bit         m_ovf, m_col, m_bad;

  int  rdy_mode = 0;   // 0 random, 1 stall, 2 always accept
  time hs_time  = 0;
  time xfer_time = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_map = '0;
    m_cnt = 0;
    m_ovf = 0;
    m_col = 0;
    m_bad = 0;
  endtask

  task automatic model_apply(input logic [15:0] w, input bit last);
    bit [7:0] s[2];
    exp_t e;
    s[0] = w[7:0];
    s[1] = w[15:8];
    if (s[0] == 8'hFF && s[1] != 8'hFF) m_bad = 1;
    for (int k = 0; k < 2; k++) begin
      if (s[k] != 8'hFF) begin
        int a;
        int n;
        a = s[k] & 8'h7F;
        n = s[k][7] ? 2 : 1;
        m_cnt++;
        for (int j = 0; j < n; j++) begin
          if (m_map[a + j]) m_col = 1;
          m_map[a + j] = 1'b1;
        end
      end
    end
    if (m_cnt > MAX_CLUS) m_ovf = 1;
    if (last) begin
      e.map = m_map;
      e.cnt = (m_cnt > 255) ? 255 : m_cnt;
      e.ovf = m_ovf;
      e.col = m_col;
      e.bad = m_bad;
      sb.push_back(e);
      model_clear();
    end
  endtask

  function automatic logic [7:0] rand_slot();
    logic [7:0] r;
    case ($urandom_range(0, 3))
      0: r = 8'hFF;
      1: r = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 15))};
      default: r = 8'($urandom_range(0, 254));
    endcase
    return r;
  endfunction

  task automatic send(input logic [15:0] w, input bit last);
    int t = 0;
    @(negedge BCclk);
    clus_in    = w;
    clus_valid = 1'b1;
    clus_last  = last;
    while (!clus_ready && t < 200) begin
      @(negedge BCclk);
      t++;
    end
    if (!clus_ready) begin
      chk("ready_timeout", 1'b0, 1'b1);
    end else begin
      model_apply(w, last);
    end
    @(posedge BCclk);
    xfer_time = $time;
    #1;
    clus_valid = 1'b0;
    clus_last  = 1'b0;
    if (last) begin
      @(negedge BCclk);
      chk("valid_latency", hitmap_valid, 1'b1);
    end
  endtask

  task automatic check_reset_state();
    chk("rst_hitmap", hitmap, '0);
    chk("rst_valid", hitmap_valid, 1'b0);
    chk("rst_count", clus_count, '0);
    chk("rst_errs", {err_overflow, err_collision, err_badslot}, 3'b000);
    chk("rst_ready", clus_ready, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge BCclk);
    #2;
    rstb = 1'b0;
    #1;
    check_reset_state();
    sb.delete();
    model_clear();
    repeat (2) @(negedge BCclk);
    #2;
    rstb = 1'b1;
    @(negedge BCclk);
    check_reset_state();
  endtask

  // Consumer / monitor: decides out_ready and scores each accepted hit map.
  logic [127:0] held_map;
  logic [7:0]   held_cnt;
  bit           held = 0;

  always @(negedge BCclk) begin
    if (!rstb) begin
      held      = 0;
      out_ready = 1'b0;
    end else if (hitmap_valid) begin
      chk("hold_ready_low", clus_ready, 1'b0);
      if (held) begin
        chk("hold_map_stable", hitmap, held_map);
        chk("hold_cnt_stable", clus_count, held_cnt);
      end
      case (rdy_mode)
        0: out_ready = 1'($urandom_range(0, 1));
        1: out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
      if (out_ready) begin
        held    = 0;
        hs_time = $time + 5;
        if (sb.size() == 0) begin
          chk("unexpected_output", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("hitmap", hitmap, e.map);
          chk("clus_count", clus_count, 8'(e.cnt));
          chk("err_overflow", err_overflow, e.ovf);
          chk("err_collision", err_collision, e.col);
          chk("err_badslot", err_badslot, e.bad);
        end
      end else begin
        held     = 1;
        held_map = hitmap;
        held_cnt = clus_count;
      end
    end else begin
      held      = 0;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int t;
    rstb       = 1'b0;
    clus_in    = '0;
    clus_valid = 1'b0;
    clus_last  = 1'b0;
    out_ready  = 1'b0;
    model_clear();
    repeat (3) @(negedge BCclk);
    #1;
    check_reset_state();
    #1;
    rstb = 1'b1;

    send(16'hFF05, 1);
    send(16'h7F80, 1);
    send(16'hFF8A, 0);
    send(16'hFF0B, 1);
    send(16'h05FF, 1);

    // Stall the consumer for 5 cycles, then release it while a word waits.
    @(posedge BCclk); #1; rdy_mode = 1;
    send(16'h3C12, 1);
    repeat (5) @(negedge BCclk);
    @(posedge BCclk); #1; rdy_mode = 2;
    send(16'hFF40, 1);
    chk("accept_after_release", 64'(xfer_time - hs_time), 64'd10);
    rdy_mode = 0;

    for (int i = 0; i < 33; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 254));
      b = 8'($urandom_range(0, 254));
      send({b, a}, i == 32);
    end

    for (int ev = 0; ev < 40; ev++) begin
      int nw;
      nw = $urandom_range(1, 5);
      for (int i = 0; i < nw; i++) begin
        send({rand_slot(), rand_slot()}, i == nw - 1);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge BCclk);
      end
    end

    // Reset in the middle of an event, then again while an output is held.
    send(16'h0102, 0);
    send(16'h0304, 0);
    do_reset();
    @(posedge BCclk); #1; rdy_mode = 1;
    send(16'h2010, 1);
    repeat (2) @(negedge BCclk);
    do_reset();
    rdy_mode = 2;
    send(16'hFFFF, 1);

    t = 0;
    while ((sb.size() != 0 || hitmap_valid) && t < 200) begin
      @(negedge BCclk);
      t++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cluster_decode_128bit.md
Name: cluster_decode_128bit

Overview:
- Readout-side inverse of the front-end cluster finder.
- Accepts a stream of 16-bit cluster words, two 8-bit cluster slots per word, belonging to one bunch crossing (event).
- Rebuilds the 128-strip hit map for that event and presents it with a valid/ready handshake.
- Used in the HSIO-side checker to compare decoded strip maps against injected strip patterns.

Parameters:
- MAX_CLUS, 64, maximum non-empty clusters per event before the overflow flag is set.
- CNT_W, 8, width of the cluster counter. Must satisfy 2^CNT_W > MAX_CLUS.

Ports:
- BCclk  input  1  bunch-crossing clock; all logic on the rising edge.
- rstb  input  1  asynchronous, active-low reset.
- clus_in  input  16  cluster word. [7:0] is slot0, processed first; [15:8] is slot1.
- clus_valid  input  1  clus_in is valid.
- clus_last  input  1  qualifies clus_in as the final word of the event.
- clus_ready  output  1  decoder accepts a word this cycle.
- hitmap  output  128  decoded strip map; bit n is strip n.
- hitmap_valid  output  1  hitmap and the flags below are valid.
- out_ready  input  1  consumer accepts hitmap.
- clus_count  output  CNT_W  number of non-empty slots in the event, saturating.
- err_overflow  output  1  clus_count exceeded MAX_CLUS.
- err_collision  output  1  a decoded strip was already set in this event.
- err_badslot  output  1  illegal slot code was seen.

Behaviour:
- Slot format: [6:0] strip address A; [7] is the double flag.
  - flag=0 sets strip A.
  - flag=1 sets strips A and A+1.
  - 8'hFF is an empty slot: no strips, not counted.
  - 8'h7F (single hit on strip 127) is legal.
  - No other code with flag=1 and A=127 exists besides 8'hFF, so there is no illegal double at the edge.
  - err_badslot is raised for an empty slot0 followed by a non-empty slot1 (ordering violation). Slot1 is still decoded.
- Word transfer: a word is transferred when clus_valid && clus_ready.
- FSM, two states:
  - ACCUM (reset state): clus_ready=1.
    - Each transfer ORs both slot masks into the accumulator, adds the non-empty slot count (0..2) to the counter, and ORs the error terms into the sticky flags.
    - A transfer with clus_last=1 copies the accumulator, including the word currently being transferred, plus count and flags into the output registers. It then clears the accumulator, count and flags, and moves to HOLD.
  - HOLD: clus_ready=0 and hitmap_valid=1.
    - On out_ready=1: hitmap_valid=0 and clus_ready=1 from the next cycle; return to ACCUM.
- Latency: last word accepted in cycle N gives hitmap_valid=1 in cycle N+1. At most one event is buffered.
- Collision: raised if a slot mask overlaps the accumulator, or if the slot0 and slot1 masks of the same word overlap. The hit is still ORed in.
- Counter:
  - Saturates at 2^CNT_W−1.
  - err_overflow is set when the running count, after adding the current word, exceeds MAX_CLUS.
- Outputs hold their values while in HOLD. Input changes in HOLD are ignored.
- Reset, including mid-event or mid-HOLD:
  - state=ACCUM, hitmap=0, hitmap_valid=0, clus_count=0, all err_* =0, accumulator cleared.
  - clus_ready=1 after reset release.
- An event may consist of one word containing two empty slots with clus_last=1. This gives hitmap=0, count=0, no errors.

Decomposition:
- Package cluster_pkg holds:
  - STRIP_W=128, ADDR_W=7, SLOT_W=8.
  - EMPTY_SLOT=8'hFF, DOUBLE_BIT=7.
  - A function returning the non-empty indicator for a slot.
- Sub-module cluster_slot_decode: combinational, SLOT_W in to STRIP_W mask out, plus empty and badcode outputs. The top level instantiates it twice.
- The top level holds the FSM, accumulator, counter and output registers.

Test Plan:
- Reset, then one word 16'hFF05 with clus_last=1 -> next cycle hitmap_valid=1, hitmap bit5 only, clus_count=1, no errors.
- Word 16'h7F80 (double at strip 0, single at strip 127) with clus_last=1 -> hitmap bits 0, 1 and 127 set, count=2.
- Two words: 16'hFF8A, then 16'hFF0B with clus_last=1 -> bits 10 and 11 set, err_collision=1, count=2.
- Hold out_ready=0 for 5 cycles after valid -> clus_ready=0, hitmap stable; the next word is accepted only in the cycle after out_ready=1.
- 33 words of two non-empty slots each, with MAX_CLUS=64 and the last word flagged -> clus_count=66, err_overflow=1.
- Assert rstb low mid-event and again during HOLD -> all outputs 0 and clus_ready=1 after release; a subsequent 16'hFFFF last word gives hitmap=0 and count=0.
